tree_fanout_node: RTL and testbench



---
 rtl/tree_node_pkg.sv | 19 +
 rtl/tree_fanout_node_rr_arbiter.sv | 46 ++++
 rtl/tree_fanout_node.sv | 146 ++++++++++++++
 tb/tb_tree_fanout_node.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tree_node_pkg.sv
// Shared types and helpers for tree_fanout_node: request FSM states,
// drop counter width and a one-hot decoder.
package tree_node_pkg;

    typedef enum logic [1:0] {
        IDLE,
        UNI,
        BC
    } state_t;

    localparam int DROP_CNT_W   = 8;
    localparam int MAX_CHILDREN = 64;

    // Callers truncate the result to their own child count.
    function automatic logic [MAX_CHILDREN-1:0] onehot(input int idx);
        onehot = MAX_CHILDREN'(1) << idx;
    endfunction

endpackage

// File: rtl/tree_fanout_node_rr_arbiter.sv
// Rotating-priority arbiter: searches upward from r_ptr and moves the pointer
// past the winner only when the caller consumes the grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_sel;
    logic          w_found;
    int            w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        w_sel     = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N) w_idx = w_idx - N;
            w_sel = IW'(w_idx);
            if (!w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/tree_fanout_node.sv
// One tree level: routes upstream requests to one child or all children and
// merges child responses round-robin. Broadcast exists only with TREE_NODE_BCAST_EN.
module tree_fanout_node
    import tree_node_pkg::*;
#(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 32,
    parameter int ID_W         = $clog2(NUM_CHILDREN)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_bcast,
    input  logic [ID_W-1:0]                req_dest,
    input  logic [DATA_W-1:0]              req_data,
    output logic [NUM_CHILDREN-1:0]        dn_valid,
    input  logic [NUM_CHILDREN-1:0]        dn_ready,
    output logic [DATA_W-1:0]              dn_data,
    input  logic [NUM_CHILDREN-1:0]        rsp_in_valid,
    output logic [NUM_CHILDREN-1:0]        rsp_in_ready,
    input  logic [NUM_CHILDREN*DATA_W-1:0] rsp_in_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_W-1:0]              rsp_data,
    output logic [ID_W-1:0]                rsp_src,
    output logic [DROP_CNT_W-1:0]          drop_cnt
);

    state_t                r_state, w_state_nxt;
    logic [DATA_W-1:0]     r_data;
    logic [ID_W-1:0]       r_dest;
    logic                  r_alive;
    logic [DROP_CNT_W-1:0] r_drop;
    logic                  w_accept, w_legal, w_bcast;

`ifdef TREE_NODE_BCAST_EN
    logic [NUM_CHILDREN-1:0] r_pend, w_pend_nxt;
    assign w_bcast = req_bcast;
`else
    logic w_unused_bcast;
    assign w_unused_bcast = req_bcast;
    assign w_bcast        = 1'b0;
`endif

    // r_alive keeps req_ready low until the first edge after reset release.
    assign req_ready = r_alive && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_legal   = int'(req_dest) < NUM_CHILDREN;
    assign dn_data   = r_data;
    assign drop_cnt  = r_drop;

    always_comb begin
        w_state_nxt = r_state;
        dn_valid    = '0;
`ifdef TREE_NODE_BCAST_EN
        w_pend_nxt  = r_pend;
`endif
        case (r_state)
            IDLE: begin
`ifdef TREE_NODE_BCAST_EN
                if (w_accept && w_bcast) begin
                    w_state_nxt = BC;
                    w_pend_nxt  = '1;
                end else
`endif
                if (w_accept && w_legal) w_state_nxt = UNI;
            end
            UNI: begin
                dn_valid = NUM_CHILDREN'(onehot(int'(r_dest)));
                if (dn_ready[r_dest]) w_state_nxt = IDLE;
            end
`ifdef TREE_NODE_BCAST_EN
            BC: begin
                dn_valid   = r_pend;
                w_pend_nxt = r_pend & ~dn_ready;
                if (w_pend_nxt == '0) w_state_nxt = IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_dest  <= '0;
            r_alive <= 1'b0;
            r_drop  <= '0;
`ifdef TREE_NODE_BCAST_EN
            r_pend  <= '0;
`endif
        end else begin
            r_alive <= 1'b1;
            r_state <= w_state_nxt;
`ifdef TREE_NODE_BCAST_EN
            r_pend  <= w_pend_nxt;
`endif
            if (w_accept) begin
                r_data <= req_data;
                r_dest <= req_dest;
            end
            if (w_accept && !w_bcast && !w_legal && r_drop != '1)
                r_drop <= r_drop + 1'b1;
        end
    end

    // Response path: output register refills when empty or draining this cycle.
    logic                    w_load;
    logic [NUM_CHILDREN-1:0] w_grant;
    logic [ID_W-1:0]         w_gidx;
    logic                    r_rsp_valid;
    logic [DATA_W-1:0]       r_rsp_data;
    logic [ID_W-1:0]         r_rsp_src;

    assign w_load       = !r_rsp_valid || rsp_ready;
    assign rsp_in_ready = w_load ? w_grant : '0;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_src      = r_rsp_src;

    rr_arbiter #(.N(NUM_CHILDREN), .IW(ID_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (rsp_in_valid),
        .advance   (w_load),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_src   <= '0;
        end else if (w_load) begin
            r_rsp_valid <= |rsp_in_valid;
            if (|rsp_in_valid) begin
                r_rsp_data <= rsp_in_data[int'(w_gidx)*DATA_W +: DATA_W];
                r_rsp_src  <= w_gidx;
            end
        end
    end

endmodule

// File: tb/tb_tree_fanout_node.sv
// Directed bench for tree_fanout_node: unicast/illegal vectors from a table,
// plus hand sequences for broadcast, saturation, reset abort, fairness, backpressure.
module tb_tree_fanout_node;

    localparam int NC = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_bcast;
    logic [IW-1:0]    req_dest;
    logic [DW-1:0]    req_data;
    logic [NC-1:0]    dn_valid, dn_ready;
    logic [DW-1:0]    dn_data;
    logic [NC-1:0]    rsp_in_valid, rsp_in_ready;
    logic [NC*DW-1:0] rsp_in_data;
    logic             rsp_valid, rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_src;
    logic [7:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tree_fanout_node #(.NUM_CHILDREN(NC), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_bcast(req_bcast),
        .req_dest(req_dest), .req_data(req_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready), .rsp_in_data(rsp_in_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_src(rsp_src), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [IW-1:0] dest;
        logic [DW-1:0] data;
        logic [NC-1:0] exp_dn;
        logic [7:0]    exp_drop;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{4'd3,  32'hA5A5_0003, 10'h008, 8'd0};
        vt[1] = '{4'd0,  32'h1111_0000, 10'h001, 8'd0};
        vt[2] = '{4'd9,  32'h9999_0009, 10'h200, 8'd0};
        vt[3] = '{4'd12, 32'hDEAD_000C, 10'h000, 8'd1};
        vt[4] = '{4'd15, 32'hDEAD_000F, 10'h000, 8'd2};

        rst = 1'b1; req_valid = 1'b0; req_bcast = 1'b0; req_dest = '0; req_data = '0;
        dn_ready = '1; rsp_in_valid = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NC; i++) rsp_in_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);

        #12;
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst dn_valid", 64'(dn_valid), 64'd0);
        chk("rst dn_data", 64'(dn_data), 64'd0);
        chk("rst rsp_in_ready", 64'(rsp_in_ready), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_data", 64'(rsp_data), 64'd0);
        chk("rst rsp_src", 64'(rsp_src), 64'd0);
        chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk) rst = 1'b0;
        #1 chk("ready before first edge", 64'(req_ready), 64'd0);
        tick();
        chk("ready after first edge", 64'(req_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_dest = vt[i].dest; req_data = vt[i].data;
            tick();
            req_valid = 1'b0;
            chk("vec dn_valid", 64'(dn_valid), 64'(vt[i].exp_dn));
            chk("vec drop_cnt", 64'(drop_cnt), 64'(vt[i].exp_drop));
            chk("vec req_ready busy", 64'(req_ready), 64'(vt[i].exp_dn == '0));
            if (vt[i].exp_dn != '0) chk("vec dn_data", 64'(dn_data), 64'(vt[i].data));
            tick();
            chk("vec dn_valid done", 64'(dn_valid), 64'd0);
            chk("vec req_ready back", 64'(req_ready), 64'd1);
        end

        // dn_valid must hold while the child stalls
        dn_ready = '0; req_valid = 1'b1; req_dest = 4'd5; req_data = 32'h5555_0005;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk("hold dn_valid", 64'(dn_valid), 64'h020);
        chk("hold dn_data", 64'(dn_data), 64'h5555_0005);
        dn_ready = 10'h020;
        tick();
        chk("hold released", 64'(dn_valid), 64'd0);
        chk("hold req_ready", 64'(req_ready), 64'd1);
        dn_ready = '1;

        req_valid = 1'b1; req_dest = 4'd12;
        repeat (300) tick();
        req_valid = 1'b0;
        chk("drop saturate", 64'(drop_cnt), 64'd255);

`ifdef TREE_NODE_BCAST_EN
        dn_ready = '0; req_bcast = 1'b1; req_valid = 1'b1; req_data = 32'hB0B0_0001;
        tick();
        req_valid = 1'b0; req_bcast = 1'b0;
        chk("bc dn_valid0", 64'(dn_valid), 64'h3FF);
        chk("bc req_ready0", 64'(req_ready), 64'd0);
        chk("bc dn_data", 64'(dn_data), 64'hB0B0_0001);
        dn_ready = 10'h00F;
        tick();
        chk("bc dn_valid1", 64'(dn_valid), 64'h3F0);
        chk("bc req_ready1", 64'(req_ready), 64'd0);
        dn_ready = 10'h3F0;
        tick();
        chk("bc dn_valid2", 64'(dn_valid), 64'd0);
        chk("bc req_ready2", 64'(req_ready), 64'd1);

        dn_ready = '1; req_bcast = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; req_bcast = 1'b0;
        chk("bc1 dn_valid", 64'(dn_valid), 64'h3FF);
        tick();
        chk("bc1 done", 64'(dn_valid), 64'd0);

        dn_ready = '0; req_bcast = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; req_bcast = 1'b0;
        dn_ready = 10'h00F;
        tick();
        dn_ready = '0;
        chk("mid bc pending", 64'(dn_valid), 64'h3F0);
`else
        dn_ready = '0; req_bcast = 1'b1; req_dest = 4'd5; req_valid = 1'b1; req_data = 32'hB0B0_0001;
        tick();
        req_valid = 1'b0; req_bcast = 1'b0;
        chk("bcast ignored", 64'(dn_valid), 64'h020);
        chk("bcast ignored ready", 64'(req_ready), 64'd0);
`endif
        #2 rst = 1'b1;
        #1;
        chk("async rst dn_valid", 64'(dn_valid), 64'd0);
        chk("async rst req_ready", 64'(req_ready), 64'd0);
        chk("async rst dn_data", 64'(dn_data), 64'd0);
        chk("async rst drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("post rst ready", 64'(req_ready), 64'd1);
        chk("post rst no resume", 64'(dn_valid), 64'd0);
        dn_ready = '1; req_valid = 1'b1; req_dest = 4'd7; req_data = 32'h7777_0007;
        tick();
        req_valid = 1'b0;
        chk("post rst uni", 64'(dn_valid), 64'h080);
        tick();
        chk("post rst uni done", 64'(dn_valid), 64'd0);
        chk("post rst uni ready", 64'(req_ready), 64'd1);

        rsp_ready = 1'b1; rsp_in_valid = '1;
        tick();
        for (int k = 0; k <= 10; k++) begin
            chk("rr valid", 64'(rsp_valid), 64'd1);
            chk("rr src", 64'(rsp_src), 64'(k % 10));
            chk("rr data", 64'(rsp_data), 64'(32'hD000_0000 + 32'(k % 10)));
            chk("rr in_ready", 64'(rsp_in_ready), 64'(1) << ((k + 1) % 10));
            if (k < 10) tick();
        end
        rsp_in_valid = '0;
        tick();
        chk("rr drained", 64'(rsp_valid), 64'd0);

        rsp_ready = 1'b0; rsp_in_valid = 10'h010;
        tick();
        rsp_in_valid = 10'h050;
        for (int c = 0; c < 5; c++) begin
            chk("bp valid", 64'(rsp_valid), 64'd1);
            chk("bp src", 64'(rsp_src), 64'd4);
            chk("bp data", 64'(rsp_data), 64'hD000_0004);
            chk("bp in_ready", 64'(rsp_in_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("bp release grant", 64'(rsp_in_ready), 64'h040);
        tick();
        chk("bp next valid", 64'(rsp_valid), 64'd1);
        chk("bp next src", 64'(rsp_src), 64'd6);
        chk("bp next data", 64'(rsp_data), 64'hD000_0006);
        chk("bp wrap grant", 64'(rsp_in_ready), 64'h010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
